// File: rtl/risc_v_pkg.sv
// Shared encodings for the CPU memory subsystem: arbiter states, port owners
// and the supported memory latency window.
package risc_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;
    // Wide enough to hold MEM_LATENCY_MAX.
    localparam int CNT_WIDTH       = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win
// last time is chosen.
module rr_arbiter2
    import risc_v_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_owner
);

    logic [1:0] eligible;

    assign eligible    = req & ~mask;
    assign grant_valid = |eligible;
    assign grant_owner = (&eligible) ? ~last_grant : eligible[OWNER_D];

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one memory port
// with a fixed read latency; read data and ready pulses are registered.
module mem_arbiter
    import risc_v_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_we;
    logic                  grant_valid;
    logic                  grant_owner;

    // A port whose ready pulse is visible this cycle is masked, so the
    // request it is about to drop cannot be granted a second time.
    rr_arbiter2 u_rr (
        .req         ({d_req, if_req}),
        .mask        ({d_ready, if_ready}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= OWNER_IF;
            last_grant <= OWNER_D;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        if (grant_owner == OWNER_D) begin
                            lat_addr  <= d_addr;
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                        end else begin
                            lat_addr  <= if_addr;
                            lat_we    <= 1'b0;
                            lat_wdata <= '0;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CNT_WIDTH'(MEM_LATENCY);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Last wait cycle: mem_rdata is valid now.
                    if (cnt <= CNT_WIDTH'(1)) begin
                        cnt <= '0;
                        if (owner == OWNER_D) begin
                            d_ready <= 1'b1;
                            if (!lat_we) d_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with latency 1, one with 3.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, busy;

    logic        b_if_req, b_d_req, b_d_we;
    logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0aaa;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0bbb; d_wdata = 32'h0000_0ccc;
        mem_rdata = 32'hffff_ffff;
        b_if_req = 1'b1; b_if_addr = 32'h0000_0ddd;
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h0000_0eee; b_d_wdata = 32'h0000_0fff;
        b_mem_rdata = 32'hffff_ffff;
        #2 reset = 1'b0;
        tick(); tick();

        // Reset with requests active: every output is zero.
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_b_mem_en", {31'd0, b_mem_en}, 32'd0);
        check("rst_b_busy", {31'd0, b_busy}, 32'd0);

        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // First fetch after reset.
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        check("f1_mem_en", {31'd0, mem_en}, 32'd1);
        check("f1_mem_addr", mem_addr, 32'h10);
        check("f1_mem_we", {31'd0, mem_we}, 32'd0);
        check("f1_busy", {31'd0, busy}, 32'd1);
        mem_rdata = 32'h1111_1111;
        tick();
        check("f1_wait_en", {31'd0, mem_en}, 32'd0);
        check("f1_wait_busy", {31'd0, busy}, 32'd1);
        check("f1_wait_ready", {31'd0, if_ready}, 32'd0);
        mem_rdata = 32'hdead_beef;
        tick();
        check("f1_ready", {31'd0, if_ready}, 32'd1);
        check("f1_rdata", if_rdata, 32'hdead_beef);
        check("f1_idle_busy", {31'd0, busy}, 32'd0);
        if_req = 1'b0;
        tick();
        check("f1_ready_pulse", {31'd0, if_ready}, 32'd0);
        check("f1_rdata_hold", if_rdata, 32'hdead_beef);
        check("f1_no_regrant", {31'd0, mem_en}, 32'd0);

        // Store; late changes to address/data must be ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        tick();
        check("st_mem_en", {31'd0, mem_en}, 32'd1);
        check("st_mem_we", {31'd0, mem_we}, 32'd1);
        check("st_mem_addr", mem_addr, 32'h40);
        check("st_mem_wdata", mem_wdata, 32'h1234);
        d_addr = 32'h99; d_wdata = 32'h5555;
        tick();
        check("st_wait_we", {31'd0, mem_we}, 32'd0);
        check("st_wait_addr", mem_addr, 32'h40);
        mem_rdata = 32'hcafe_f00d;
        tick();
        check("st_ready", {31'd0, d_ready}, 32'd1);
        check("st_rdata_kept", d_rdata, 32'd0);
        check("st_if_ready", {31'd0, if_ready}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("st_ready_pulse", {31'd0, d_ready}, 32'd0);

        // Tie after a data grant: fetch first, data granted in the fetch ready cycle.
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h44; d_wdata = 32'h0;
        tick();
        check("tie_f_en", {31'd0, mem_en}, 32'd1);
        check("tie_f_addr", mem_addr, 32'h20);
        tick();
        mem_rdata = 32'ha5a5_a5a5;
        tick();
        check("tie_f_ready", {31'd0, if_ready}, 32'd1);
        check("tie_f_rdata", if_rdata, 32'ha5a5_a5a5);
        check("tie_d_notyet", {31'd0, d_ready}, 32'd0);
        if_req = 1'b0;
        tick();
        check("tie_d_en", {31'd0, mem_en}, 32'd1);
        check("tie_d_addr", mem_addr, 32'h44);
        check("tie_d_we", {31'd0, mem_we}, 32'd0);
        tick();
        mem_rdata = 32'h5a5a_5a5a;
        tick();
        check("tie_d_ready", {31'd0, d_ready}, 32'd1);
        check("tie_d_rdata", d_rdata, 32'h5a5a_5a5a);
        check("tie_if_quiet", {31'd0, if_ready}, 32'd0);
        d_req = 1'b0;
        tick();
        check("tie_d_pulse", {31'd0, d_ready}, 32'd0);

        // Same port holds req through ready: one-cycle gap before next ISSUE.
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        check("mk_en1", {31'd0, mem_en}, 32'd1);
        check("mk_addr1", mem_addr, 32'h30);
        tick();
        mem_rdata = 32'h0000_0001;
        tick();
        check("mk_ready1", {31'd0, if_ready}, 32'd1);
        check("mk_rdata1", if_rdata, 32'h1);
        if_addr = 32'h34;
        tick();
        check("mk_gap_en", {31'd0, mem_en}, 32'd0);
        check("mk_gap_busy", {31'd0, busy}, 32'd0);
        tick();
        check("mk_en2", {31'd0, mem_en}, 32'd1);
        check("mk_addr2", mem_addr, 32'h34);
        tick();
        mem_rdata = 32'h0000_0002;
        tick();
        check("mk_ready2", {31'd0, if_ready}, 32'd1);
        check("mk_rdata2", if_rdata, 32'h2);
        if_req = 1'b0;
        tick();

        // Reset during WAIT of a fetch: abandon, no ready; next tie goes to fetch.
        if_req = 1'b1; if_addr = 32'h50;
        tick();
        check("mr_en", {31'd0, mem_en}, 32'd1);
        tick();
        mem_rdata = 32'h7777_7777;
        reset = 1'b0;
        #1;
        check("mr_en_low", {31'd0, mem_en}, 32'd0);
        check("mr_we_low", {31'd0, mem_we}, 32'd0);
        check("mr_busy_low", {31'd0, busy}, 32'd0);
        if_req = 1'b0;
        tick();
        check("mr_no_ready", {31'd0, if_ready}, 32'd0);
        check("mr_rdata_cleared", if_rdata, 32'd0);
        reset = 1'b1;
        tick();
        check("mr_no_ready2", {31'd0, if_ready}, 32'd0);
        if_req = 1'b1; if_addr = 32'h60;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h64;
        tick();
        check("mr_tie_en", {31'd0, mem_en}, 32'd1);
        check("mr_tie_addr", mem_addr, 32'h60);
        tick();
        mem_rdata = 32'h6060_6060;
        tick();
        check("mr_tie_ready", {31'd0, if_ready}, 32'd1);
        if_req = 1'b0;
        tick();
        check("mr_d_en", {31'd0, mem_en}, 32'd1);
        check("mr_d_addr", mem_addr, 32'h64);
        tick();
        mem_rdata = 32'h6464_6464;
        tick();
        check("mr_d_ready", {31'd0, d_ready}, 32'd1);
        check("mr_d_rdata", d_rdata, 32'h6464_6464);
        d_req = 1'b0;
        tick();

        // Latency 3: only the last WAIT cycle's mem_rdata is captured.
        b_if_req = 1'b1; b_if_addr = 32'h80;
        tick();
        check("l3_en", {31'd0, b_mem_en}, 32'd1);
        check("l3_addr", b_mem_addr, 32'h80);
        tick();
        check("l3_w1_en", {31'd0, b_mem_en}, 32'd0);
        check("l3_w1_busy", {31'd0, b_busy}, 32'd1);
        b_mem_rdata = 32'hbad0_bad0;
        tick();
        check("l3_w2_ready", {31'd0, b_if_ready}, 32'd0);
        b_mem_rdata = 32'hbad1_bad1;
        tick();
        check("l3_w3_ready", {31'd0, b_if_ready}, 32'd0);
        check("l3_w3_busy", {31'd0, b_busy}, 32'd1);
        b_mem_rdata = 32'h8765_4321;
        tick();
        check("l3_ready", {31'd0, b_if_ready}, 32'd1);
        check("l3_rdata", b_if_rdata, 32'h8765_4321);
        check("l3_idle", {31'd0, b_busy}, 32'd0);
        b_if_req = 1'b0;
        b_mem_rdata = 32'h0;
        tick();
        check("l3_pulse", {31'd0, b_if_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares the single-ported data memory between the CPU instruction-fetch path and the load/store path, so fetch and data no longer need separate memories. Each side issues requests over a req/ready handshake. The arbiter serialises the requests onto one memory port with a fixed, parameterised read latency, and returns read data in registered form. It sits between `risc_v_cpu` (two requester ports) and `memory` (single port).

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width, both ports and memory.
- `DATA_WIDTH`, default 32: data width.
- `MEM_LATENCY`, default 1: cycles from the memory issue cycle to valid `mem_rdata`. Legal range 1..4.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `if_req`  in  1: fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_WIDTH: fetch address; stable while `if_req`.
- `if_rdata`  out  DATA_WIDTH: fetched word; registered.
- `if_ready`  out  1: one-cycle completion pulse.
- `d_req`  in  1: data request.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH: data address.
- `d_wdata`  in  DATA_WIDTH: store data.
- `d_rdata`  out  DATA_WIDTH: load result; registered.
- `d_ready`  out  1: one-cycle completion pulse.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_WIDTH: memory address.
- `mem_wdata`  out  DATA_WIDTH: memory write data.
- `mem_rdata`  in  DATA_WIDTH: memory read data.
- `busy`  out  1: access in flight (ISSUE or WAIT).

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - Sample requests.
  - If any eligible request exists, pick an owner, latch its address, `we` and `wdata` into internal registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - Exactly one cycle.
  - `mem_en`=1, and `mem_addr`/`mem_wdata` come from the latched registers.
  - `mem_we` = latched `we` (always 0 for a fetch).
  - Load the wait counter with `MEM_LATENCY`, then go to WAIT.
- **WAIT:**
  - Lasts `MEM_LATENCY` cycles, counted down.
  - `mem_en`=0.
  - In the last WAIT cycle:
    - On a read, capture `mem_rdata` into the owner's rdata register.
    - Set the owner's ready register for exactly one cycle.
    - Return to IDLE.
- **Stores:**
  - Same timing as loads; `d_ready` still pulses.
  - `d_rdata` keeps its previous value.
- **Arbitration:** round-robin over the two ports.
  - A `last_grant` bit records the owner of the most recent grant.
  - When both ports are eligible, grant the port that is not `last_grant`.
  - After reset, `last_grant` = data, so fetch wins the first tie.
- **Ready-cycle mask:**
  - During the IDLE cycle in which X_ready=1, port X is ineligible.
  - Reason: the requester drops `req` on that same edge, and a still-high `req` must not be re-granted.
  - The other port may be granted in that cycle.
  - Port X is eligible again from the following cycle.
- **Requester rules:**
  - Address, `we` and `wdata` are latched at grant, so later changes have no effect.
  - Dropping `req` before ready is illegal; the access completes regardless.
- **Mid-operation reset:** `reset` low in any state gives, immediately:
  - state IDLE;
  - `mem_en`=0 and `mem_we`=0;
  - the in-flight access abandoned, with no ready pulse.

## Timing
- Reset values:
  - all outputs 0, including `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata`;
  - state IDLE, counter 0, `last_grant`=data.
- Latency: `req` first sampled high in IDLE cycle 0 gives:
  - ISSUE in cycle 1;
  - WAIT in cycles 2..1+L, with `mem_rdata` sampled at the end of cycle 1+L;
  - ready and rdata valid in cycle 2+L.
- Throughput:
  - One access per L+2 cycles.
  - Back-to-back alternating requests reach that rate, because the other port is granted in the ready cycle.
  - The same port re-requesting loses one extra cycle to the mask.
- `busy`=1 exactly in ISSUE and WAIT.
- All outputs are registered or decoded from state/latched registers. There is no combinational path from `req` to any output.

## Structure
- Shared package `risc_v_pkg` holds:
  - state encoding constants (IDLE/ISSUE/WAIT);
  - owner encoding (`OWNER_IF`=0, `OWNER_D`=1);
  - latency bounds.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `mask[1:0]`, `last_grant`.
  - Outputs: `grant_valid`, `grant_owner`.
- The FSM, counter, latches and response registers live in `mem_arbiter`.

## Test plan
All scenarios use L=1 unless noted.
- **Reset:**
  - Drive `reset` low with requests active: all outputs 0.
  - Release `reset`, then set `if_req` with `if_addr`=0x10: `mem_en` pulses in cycle 1 with `mem_addr`=0x10.
  - With `mem_rdata`=0xDEADBEEF in cycle 2: `if_ready`=1 and `if_rdata`=0xDEADBEEF in cycle 3.
- **Store:**
  - `d_req`, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x1234.
  - Expect in the ISSUE cycle: `mem_en`=1, `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x1234.
  - Expect `d_ready` in cycle 3 with `d_rdata` unchanged.
- **Tie after reset:**
  - Assert `if_req` and `d_req` in the same cycle: fetch is served first.
  - Data is granted in the fetch ready cycle, with its `mem_en` one cycle later.
  - Check that no ready pulse is ever lost.
- **Mask:**
  - Fetch alone, holding `if_req` high through `if_ready`: no grant in the ready cycle.
  - The next fetch ISSUE occurs 2 cycles after `if_ready`.
- **Latency sweep:**
  - L=3, read at 0x80: ready in cycle 5.
  - `mem_rdata` is sampled only in cycle 4; garbage in cycles 2-3 is ignored.
- **Mid-operation reset:**
  - Assert `reset` during WAIT: `mem_en`/`mem_we`=0 immediately, and no ready pulse.
  - After release, the first tie goes to fetch.
